// File: rtl/nerv_axi_lite_mem_if.sv
// AXI4-Lite bus bundle between the nerv core (master) and its memory (slave).
// Signal names match the nerv axi_* port naming.
interface nerv_axi_lite_mem_if;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
               axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
               axi_rvalid, axi_rdata, axi_rresp
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
               axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
               axi_rvalid, axi_rdata, axi_rresp
    );
endinterface

// File: rtl/nerv_axi_lite_mem.sv
// AXI4-Lite slave RAM: one outstanding write and one outstanding read, byte strobes,
// SLVERR outside the window. Define NERVAXI_MEM_STALL_EN to add STALL_CYCLES response delay.
module nerv_axi_lite_mem #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic               clock,
    input  logic               resetn,
    nerv_axi_lite_mem_if.slave axi
);
    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  STALL_LD = 4'(STALL_CYCLES);

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_HAVE_AW = 3'd1,
        W_HAVE_W  = 3'd2,
`ifdef NERVAXI_MEM_STALL_EN
        W_WAIT    = 3'd4,
`endif
        W_RESP    = 3'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
`ifdef NERVAXI_MEM_STALL_EN
        R_WAIT = 2'd2,
`endif
        R_RESP = 2'd1
    } r_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < 32'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_r [MEM_WORDS];

    w_state_t    w_state_r;
    r_state_t    r_state_r;
    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic        rvalid_r;
    logic [1:0]  rresp_r;
    logic [31:0] rdata_r;
`ifdef NERVAXI_MEM_STALL_EN
    logic [3:0]  w_cnt_r;
    logic [3:0]  r_cnt_r;
`endif

    logic        awready_s;
    logic        wready_s;
    logic        arready_s;
    logic        aw_fire_s;
    logic        w_fire_s;
    logic        ar_fire_s;
    logic        wr_commit_s;
    logic [31:0] wr_addr_s;
    logic [31:0] wr_data_s;
    logic [3:0]  wr_strb_s;
    logic        unused_s;

    // Readies from state only; commit uses held or live AW/W depending on which arrived first.
    always_comb begin
        awready_s = resetn && ((w_state_r == W_IDLE) || (w_state_r == W_HAVE_W));
        wready_s  = resetn && ((w_state_r == W_IDLE) || (w_state_r == W_HAVE_AW));
        arready_s = resetn && (r_state_r == R_IDLE);
        aw_fire_s = axi.axi_awvalid && awready_s;
        w_fire_s  = axi.axi_wvalid && wready_s;
        ar_fire_s = axi.axi_arvalid && arready_s;
        wr_addr_s = (w_state_r == W_HAVE_AW) ? awaddr_r : axi.axi_awaddr;
        wr_data_s = (w_state_r == W_HAVE_W) ? wdata_r : axi.axi_wdata;
        wr_strb_s = (w_state_r == W_HAVE_W) ? wstrb_r : axi.axi_wstrb;
        case (w_state_r)
            W_IDLE:    wr_commit_s = aw_fire_s && w_fire_s;
            W_HAVE_AW: wr_commit_s = w_fire_s;
            W_HAVE_W:  wr_commit_s = aw_fire_s;
            default:   wr_commit_s = 1'b0;
        endcase
    end

    assign axi.axi_awready = awready_s;
    assign axi.axi_wready  = wready_s;
    assign axi.axi_arready = arready_s;
    assign axi.axi_bvalid  = bvalid_r;
    assign axi.axi_bresp   = bresp_r;
    assign axi.axi_rvalid  = rvalid_r;
    assign axi.axi_rresp   = rresp_r;
    assign axi.axi_rdata   = rdata_r;
    assign unused_s        = ^{axi.axi_awprot, axi.axi_arprot, STALL_LD};

    // Byte-masked RAM write on the commit edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_commit_s && addr_in_range(wr_addr_s)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_s[b]) begin
                    mem_r[addr_index(wr_addr_s)][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Write channel FSM with AW/W holding registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_state_r <= W_IDLE;
            awaddr_r  <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
`ifdef NERVAXI_MEM_STALL_EN
            w_cnt_r   <= 4'd0;
`endif
        end else begin
            if (aw_fire_s) begin
                awaddr_r <= axi.axi_awaddr;
            end
            if (w_fire_s) begin
                wdata_r <= axi.axi_wdata;
                wstrb_r <= axi.axi_wstrb;
            end
            if (wr_commit_s) begin
                bresp_r <= addr_in_range(wr_addr_s) ? 2'b00 : 2'b10;
`ifdef NERVAXI_MEM_STALL_EN
                if (STALL_LD == 4'd0) begin
                    w_state_r <= W_RESP;
                    bvalid_r  <= 1'b1;
                end else begin
                    w_state_r <= W_WAIT;
                    w_cnt_r   <= STALL_LD;
                end
`else
                w_state_r <= W_RESP;
                bvalid_r  <= 1'b1;
`endif
            end else begin
                case (w_state_r)
                    W_IDLE: begin
                        if (aw_fire_s) begin
                            w_state_r <= W_HAVE_AW;
                        end else if (w_fire_s) begin
                            w_state_r <= W_HAVE_W;
                        end
                    end
                    W_HAVE_AW, W_HAVE_W: w_state_r <= w_state_r;
`ifdef NERVAXI_MEM_STALL_EN
                    W_WAIT: begin
                        if (w_cnt_r <= 4'd1) begin
                            w_state_r <= W_RESP;
                            bvalid_r  <= 1'b1;
                        end else begin
                            w_cnt_r <= w_cnt_r - 4'd1;
                        end
                    end
`endif
                    W_RESP: begin
                        if (axi.axi_bready) begin
                            w_state_r <= W_IDLE;
                            bvalid_r  <= 1'b0;
                        end
                    end
                    default: begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read channel FSM; data is sampled at AR accept so a same-edge write is not seen.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= 32'd0;
`ifdef NERVAXI_MEM_STALL_EN
            r_cnt_r   <= 4'd0;
`endif
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        rdata_r <= addr_in_range(axi.axi_araddr) ? mem_r[addr_index(axi.axi_araddr)] : 32'd0;
                        rresp_r <= addr_in_range(axi.axi_araddr) ? 2'b00 : 2'b10;
`ifdef NERVAXI_MEM_STALL_EN
                        if (STALL_LD == 4'd0) begin
                            r_state_r <= R_RESP;
                            rvalid_r  <= 1'b1;
                        end else begin
                            r_state_r <= R_WAIT;
                            r_cnt_r   <= STALL_LD;
                        end
`else
                        r_state_r <= R_RESP;
                        rvalid_r  <= 1'b1;
`endif
                    end
                end
`ifdef NERVAXI_MEM_STALL_EN
                R_WAIT: begin
                    if (r_cnt_r <= 4'd1) begin
                        r_state_r <= R_RESP;
                        rvalid_r  <= 1'b1;
                    end else begin
                        r_cnt_r <= r_cnt_r - 4'd1;
                    end
                end
`endif
                R_RESP: begin
                    if (axi.axi_rready) begin
                        r_state_r <= R_IDLE;
                        rvalid_r  <= 1'b0;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
